parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Multi-channel serial parity checker. It generalises the single-bit running even/odd tracker to framed words: DATA_BITS data bits followed by one parity bit. Each frame is checked against a selectable even/odd convention, and the block reports per-frame done/error pulses and a saturating per-channel error count. It sits behind the serial receive front end, one lane per channel.

## Interface
Parameters:
- CHANNELS, 4, number of independent serial lanes
- DATA_BITS, 8, data bits per frame (≥1); frame length is DATA_BITS+1
- CNT_W, 8, width of each error counter

Ports:
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  reset, asynchronous assert, active-low
- mode_odd  in  1  0 = even parity, 1 = odd parity; sampled per frame
- resync  in  CHANNELS  per-lane frame abort/realign
- clear_cnt  in  1  synchronous clear of all error counters
- in_valid  in  CHANNELS  per-lane bit strobe
- in_bit  in  CHANNELS  per-lane serial bit, qualified by in_valid
- run_par  out  CHANNELS  running XOR of data bits accepted so far in the current frame
- frame_done  out  CHANNELS  1-cycle pulse: parity bit accepted
- frame_err  out  CHANNELS  1-cycle pulse, coincident with frame_done: parity mismatch
- err_count  out  CHANNELS*CNT_W  lane i at bits [i*CNT_W +: CNT_W], saturating

## Operation
- Lanes are fully independent. No cross-lane state except shared mode_odd and clear_cnt.
- Per-lane FSM has two states:
  - DATA: on in_valid, run_par ^= in_bit and bit_cnt++. When bit_cnt reaches DATA_BITS-1 and a bit is accepted, go to PARITY.
  - PARITY: on in_valid, compare in_bit to expected = run_par ^ mode_lat. Pulse frame_done, pulse frame_err on mismatch, clear run_par and bit_cnt, return to DATA.
- mode_lat is captured from mode_odd when the first data bit of a frame is accepted (bit_cnt==0 in DATA). Changes to mode_odd mid-frame do not affect the current frame.
- No in_valid: state, bit_cnt and run_par hold. Gaps of any length are allowed.
- resync[i] sets the lane to DATA, bit_cnt=0, run_par=0, with no pulses. It has priority over a same-cycle in_valid[i]; that bit is discarded. err_count is untouched.
- err_count[i] increments by 1 on frame_err, saturating at 2^CNT_W-1.
- clear_cnt zeroes all counters. It has priority over a same-cycle increment, so the result is 0; frame_err still pulses.
- Reset (rst_n=0, any time, including mid-frame): state=DATA, bit_cnt=0, mode_lat=0, run_par=0, frame_done=0, frame_err=0, err_count=0.

## Timing
- All outputs are registered.
- run_par reflects a bit accepted at edge N from edge N onward, i.e. visible in cycle N+1.
- frame_done/frame_err assert for exactly one cycle after the edge that accepts the parity bit.
- err_count updates on that same edge.
- Back-to-back frames at one bit per cycle: frame_done pulses every DATA_BITS+1 cycles, with no dead cycle between frames.
- run_par reads 0 in the cycle after frame_done.
- Reset deassertion needs no synchronous handling beyond the standard reset synchroniser upstream. The first accepted bit is on the first edge with rst_n=1 and in_valid=1.

## Structure
- Shared package parity_pkg holds:
  - enum state_t {DATA, PARITY}
  - localparam PAR_EVEN=1'b0, PAR_ODD=1'b1
  - function bit_cnt_w(DATA_BITS) = $clog2(DATA_BITS) (minimum 1)
- Sub-module parity_lane contains one FSM, bit counter, mode latch, run_par, pulses and counter. The top generates CHANNELS instances and fans out mode_odd and clear_cnt.

## Test plan
- Even mode, lane 0, DATA_BITS=8: data 8'b1011_0000 plus parity 1 → frame_done=1, frame_err=0, err_count[0]=0. Repeat with parity 0 → frame_err=1, err_count[0]=1.
- Odd mode, lane 1: data 8'h00 plus parity 1 → no error. Toggle mode_odd to 0 after bit 3 of the next frame, send data 8'h00 plus parity 1 → no error (mode latched).
- resync on lane 2 after 5 bits, asserted with in_valid in the same cycle → run_par=0, no pulse. The next 9 bits form a clean frame and are checked correctly.
- CNT_W=2, 5 bad frames on lane 3 → err_count[3] = 1,2,3,3,3. Then clear_cnt coincident with a 6th bad frame → count 0, frame_err=1.
- All 4 lanes streaming back-to-back with random gaps and random parity, checked against a scoreboard model. Assert rst_n low mid-frame → all outputs 0 immediately; the next frame after release is checked from bit 0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame checker.
//   state_t    : per-lane frame FSM state
//   PAR_EVEN / PAR_ODD : encodings of the mode_odd input
//   bit_cnt_w  : width of the per-lane data bit counter
package parity_pkg;

  typedef enum logic {
    DATA   = 1'b0,
    PARITY = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Counter only has to reach DATA_BITS-1; never narrower than one bit.
  function automatic int bit_cnt_w(input int data_bits);
    int w;
    w = $clog2(data_bits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parity_lane.sv
// One serial lane of the parity frame checker.
// A frame is DATA_BITS data bits followed by one parity bit.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   mode_odd_i      0 = even, 1 = odd parity; latched on the first data bit
//   resync_i        abort current frame, realign to data bit 0 (no pulses)
//   clear_cnt_i     synchronous clear of the error counter
//   in_valid_i      bit strobe
//   in_bit_i        serial bit, qualified by in_valid_i
//   run_par_o       XOR of data bits accepted so far in this frame
//   frame_done_o    1-cycle pulse after the parity bit is accepted
//   frame_err_o     1-cycle pulse with frame_done_o on parity mismatch
//   err_count_o     saturating error counter
//
// state  | meaning
// DATA   | collecting data bits, bit_cnt = bits accepted so far
// PARITY | all data bits in, waiting for the parity bit
module parity_lane
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_odd_i,
  input  logic             resync_i,
  input  logic             clear_cnt_i,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  output logic             run_par_o,
  output logic             frame_done_o,
  output logic             frame_err_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int               BW       = bit_cnt_w(DATA_BITS);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             mode_lat_q, mode_lat_d;
  logic             run_par_q, run_par_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    mode_lat_d = mode_lat_q;
    run_par_d  = run_par_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (resync_i) begin
      state_d   = DATA;
      bit_cnt_d = '0;
      run_par_d = 1'b0;
    end else if (in_valid_i) begin
      unique case (state_q)
        DATA: begin
          if (bit_cnt_q == '0) mode_lat_d = mode_odd_i;
          run_par_d = run_par_q ^ in_bit_i;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          done_d    = 1'b1;
          err_d     = in_bit_i != (run_par_q ^ mode_lat_q);
          run_par_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        default: state_d = DATA;
      endcase
    end

    // Clear wins over a same-cycle increment; the error pulse is unaffected.
    cnt_d = cnt_q;
    if (clear_cnt_i)                 cnt_d = '0;
    else if (err_d && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DATA;
      bit_cnt_q  <= '0;
      mode_lat_q <= PAR_EVEN;
      run_par_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      mode_lat_q <= mode_lat_d;
      run_par_q  <= run_par_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign run_par_o    = run_par_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign err_count_o  = cnt_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-channel serial parity frame checker: CHANNELS independent lanes,
// each checking DATA_BITS data bits + 1 parity bit frames.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   mode_odd     shared parity convention (0 even, 1 odd), latched per frame
//   resync       per-lane frame abort/realign
//   clear_cnt    shared synchronous clear of all error counters
//   in_valid     per-lane bit strobe
//   in_bit       per-lane serial bit
//   run_par      per-lane running data XOR
//   frame_done   per-lane frame complete pulse
//   frame_err    per-lane parity error pulse
//   err_count    lane i at [i*CNT_W +: CNT_W], saturating
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_odd,
  input  logic [CHANNELS-1:0]       resync,
  input  logic                      clear_cnt,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_bit,
  output logic [CHANNELS-1:0]       run_par,
  output logic [CHANNELS-1:0]       frame_done,
  output logic [CHANNELS-1:0]       frame_err,
  output logic [CHANNELS*CNT_W-1:0] err_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    parity_lane #(
      .DATA_BITS (DATA_BITS),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_odd_i   (mode_odd),
      .resync_i     (resync[i]),
      .clear_cnt_i  (clear_cnt),
      .in_valid_i   (in_valid[i]),
      .in_bit_i     (in_bit[i]),
      .run_par_o    (run_par[i]),
      .frame_done_o (frame_done[i]),
      .frame_err_o  (frame_err[i]),
      .err_count_o  (err_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;

  localparam int CH   = 4;
  localparam int DB   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          mode_odd;
  logic [CH-1:0] resync;
  logic          clear_cnt;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_bit;
  logic [CH-1:0] run_par;
  logic [CH-1:0] frame_done;
  logic [CH-1:0] frame_err;
  logic [CH*CW-1:0] err_count;

  parity_frame_checker #(.CHANNELS(CH), .DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .resync     (resync),
    .clear_cnt  (clear_cnt),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .run_par    (run_par),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits per frame counted, ones counted, mode remembered.
  int   m_nbits [CH];
  int   m_ones  [CH];
  int   m_mode  [CH];
  int   m_cnt   [CH];
  bit   exp_err_q [CH][$];
  logic mode_r;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] exp_run_par();
    logic [CH-1:0] r;
    for (int l = 0; l < CH; l++) r[l] = m_ones[l][0];
    return r;
  endfunction

  function automatic logic [CH*CW-1:0] exp_counts();
    logic [CH*CW-1:0] r;
    for (int l = 0; l < CH; l++) r[l*CW +: CW] = CW'(m_cnt[l]);
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < CH; l++) begin
      m_nbits[l] = 0; m_ones[l] = 0; m_mode[l] = 0; m_cnt[l] = 0;
      exp_err_q[l].delete();
    end
  endtask

  // Apply one cycle of inputs at the falling edge and advance the model to
  // the state the DUT should show after the following rising edge.
  task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] b,
                       input logic [CH-1:0] rs, input logic clr, input logic md);
    @(negedge clk);
    in_valid = v; in_bit = b; resync = rs; clear_cnt = clr; mode_odd = md;
    if (!rst_n) return;
    for (int l = 0; l < CH; l++) begin
      if (rs[l]) begin
        m_nbits[l] = 0; m_ones[l] = 0;
      end else if (v[l]) begin
        if (m_nbits[l] < DB) begin
          if (m_nbits[l] == 0) m_mode[l] = int'(md);
          m_ones[l] += int'(b[l]);
          m_nbits[l]++;
        end else begin
          int  want;
          bit  e;
          want = (m_ones[l] + m_mode[l]) % 2;
          e = (int'(b[l]) != want);
          exp_err_q[l].push_back(e);
          if (e && m_cnt[l] < CMAX) m_cnt[l]++;
          m_nbits[l] = 0; m_ones[l] = 0;
        end
      end
      if (clr) m_cnt[l] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, mode_r);
  endtask

  // Monitor: pops expected frame results whenever a frame is due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("run_par", int'(run_par), int'(exp_run_par()));
      check("err_count", int'(err_count), int'(exp_counts()));
      for (int l = 0; l < CH; l++) begin
        bit due, e;
        due = exp_err_q[l].size() > 0;
        check($sformatf("frame_done[%0d]", l), int'(frame_done[l]), int'(due));
        e = 1'b0;
        if (due) e = exp_err_q[l].pop_front();
        check($sformatf("frame_err[%0d]", l), int'(frame_err[l]), int'(e));
      end
    end
  end

  task automatic send_frame(input int lane, input logic [DB-1:0] data,
                            input logic par, input logic clr_on_par,
                            input int flip_at, input logic exp_err,
                            input int exp_cnt, input string tag);
    logic [CH-1:0] msk;
    msk = CH'(1) << lane;
    for (int i = 0; i < DB; i++) begin
      if (i == flip_at) mode_r = ~mode_r;
      drive(msk, data[DB-1-i] ? msk : '0, '0, 1'b0, mode_r);
    end
    drive(msk, par ? msk : '0, '0, clr_on_par, mode_r);
    @(posedge clk);
    #2;
    check({tag, " done"}, int'(frame_done[lane]), 1);
    check({tag, " err"}, int'(frame_err[lane]), int'(exp_err));
    check({tag, " count"}, int'(err_count[lane*CW +: CW]), exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; mode_odd = 1'b0; resync = '0; clear_cnt = 1'b0;
    in_valid = '0; in_bit = '0; mode_r = 1'b0;
    model_reset();
    idle(2);
    check("reset run_par", int'(run_par), 0);
    check("reset done", int'(frame_done), 0);
    check("reset count", int'(err_count), 0);
    @(negedge clk); rst_n = 1'b1;

    // Even parity, lane 0: three ones need parity 1.
    mode_r = 1'b0;
    send_frame(0, 8'b1011_0000, 1'b1, 1'b0, -1, 1'b0, 0, "even ok");
    send_frame(0, 8'b1011_0000, 1'b0, 1'b0, -1, 1'b1, 1, "even bad");
    idle(3);

    // Odd parity, lane 1; mode flips mid-frame but the latched mode holds.
    mode_r = 1'b1;
    send_frame(1, 8'h00, 1'b1, 1'b0, -1, 1'b0, 0, "odd ok");
    send_frame(1, 8'h00, 1'b1, 1'b0, 4, 1'b0, 0, "odd latched");
    idle(2);

    // Resync on lane 2 after 5 bits, with a coincident valid bit discarded.
    mode_r = 1'b0;
    for (int i = 0; i < 5; i++) drive(4'b0100, 4'b0100, '0, 1'b0, mode_r);
    drive(4'b0100, 4'b0100, 4'b0100, 1'b0, mode_r);
    @(posedge clk); #2;
    check("resync run_par", int'(run_par[2]), 0);
    check("resync done", int'(frame_done[2]), 0);
    send_frame(2, 8'b1110_0000, 1'b1, 1'b0, -1, 1'b0, 0, "after resync");
    idle(2);

    // Saturating 2-bit counter on lane 3, then clear against a bad frame.
    send_frame(3, 8'h00, 1'b1, 1'b0, -1, 1'b1, 1, "sat1");
    send_frame(3, 8'h00, 1'b1, 1'b0, -1, 1'b1, 2, "sat2");
    send_frame(3, 8'h00, 1'b1, 1'b0, -1, 1'b1, 3, "sat3");
    send_frame(3, 8'h00, 1'b1, 1'b0, -1, 1'b1, 3, "sat4");
    send_frame(3, 8'h00, 1'b1, 1'b0, -1, 1'b1, 3, "sat5");
    send_frame(3, 8'h00, 1'b1, 1'b1, -1, 1'b1, 0, "clear");
    idle(2);

    // Random streaming on all lanes, with a mid-frame reset.
    for (int c = 0; c < 3000; c++) begin
      logic [CH-1:0] v, b, rs;
      logic clr;
      if (c == 1500) begin
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0; resync = '0; clear_cnt = 1'b0;
        model_reset();
        #1;
        check("midreset run_par", int'(run_par), 0);
        check("midreset done", int'(frame_done), 0);
        check("midreset err", int'(frame_err), 0);
        check("midreset count", int'(err_count), 0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int l = 0; l < CH; l++) begin
        v[l]  = (c % 400 < 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
        b[l]  = 1'($urandom);
        rs[l] = ($urandom_range(0, 99) == 0);
      end
      clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
      drive(v, b, rs, clr, mode_r);
    end
    idle(3);
    for (int l = 0; l < CH; l++)
      check($sformatf("pending[%0d]", l), exp_err_q[l].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
